// File: rtl/eth_fwd_pkg.sv
// eth_fwd_pkg: shared FSM type, buffer word layout and routing helper for eth_frame_fwd.
package eth_fwd_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} fsm_e;
  localparam int WORD_W   = 9;
  localparam int LAST_BIT = 8;
  function automatic int route_src(input int ch, input logic swap);
    return swap ? ch ^ 1 : ch;
  endfunction
endpackage

// File: rtl/eth_fwd_chan_buf.sv
// eth_fwd_chan_buf: one channel's frame RAM, write/commit/drop logic and committed-frame count.
// With ETH_FWD_STATS_EN defined it also counts committed and dropped frames.
module eth_fwd_chan_buf
  import eth_fwd_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  input  logic              rx_err,
  input  logic              rd_en,
  input  logic              rd_done,
  output logic [WORD_W-1:0] rd_word,
  output logic              has_frame,
  output logic              drop_pulse
`ifdef ETH_FWD_STATS_EN
  ,
  output logic [31:0]       stat_rx,
  output logic [31:0]       stat_drop
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [WORD_W-1:0] ram [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d, base;
  logic ovf_q, ovf_d, in_frame_q, in_frame_d, drop_q, drop_d, active, full, we, good, bad;
  // A sof restarts from the last commit point, silently discarding any partial frame.
  always_comb begin
    base = rx_sof ? commit_q : wr_ptr_q;
    active = rx_valid & (rx_sof | in_frame_q);
    full = base + AW'(1) == rd_ptr_q;
    we = active & ~full;
    good = active & rx_eof & ~rx_err & ~full & ~(ovf_q & ~rx_sof);
    bad = active & rx_eof & ~good;
    wr_ptr_d = ~active ? wr_ptr_q : bad ? commit_q : we ? base + AW'(1) : base;
    commit_d = good ? base + AW'(1) : commit_q;
    ovf_d = ~active ? ovf_q : ~rx_eof & (full | (ovf_q & ~rx_sof));
    in_frame_d = active ? ~rx_eof : in_frame_q;
    drop_d = bad;
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    cnt_d = cnt_q + AW'(good) - AW'(rd_done);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      commit_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      in_frame_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      commit_q <= commit_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      in_frame_q <= in_frame_d;
      drop_q <= drop_d;
    end
  always_ff @(posedge clk)
    if (we) ram[base] <= {rx_eof, rx_data};
  assign rd_word = ram[rd_ptr_q];
  assign has_frame = cnt_q != '0;
  assign drop_pulse = drop_q;
`ifdef ETH_FWD_STATS_EN
  logic [31:0] stat_rx_q, stat_drop_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_rx_q <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_rx_q <= stat_rx_q + 32'(good);
      stat_drop_q <= stat_drop_q + 32'(bad);
    end
  assign stat_rx = stat_rx_q;
  assign stat_drop = stat_drop_q;
`endif
endmodule

// File: rtl/eth_frame_fwd.sv
// eth_frame_fwd: multi-channel store-and-forward rx->tx frame forwarder with straight/pair-swap routing.
// Define ETH_FWD_STATS_EN to add per-channel rx/drop/tx frame counters.
module eth_frame_fwd
  import eth_fwd_pkg::*;
#(
  parameter int ETHCOUNT   = 4,
  parameter int DEPTH      = 2048,
  parameter int IFG_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_swap,
  input  logic [ETHCOUNT*8-1:0] rx_data,
  input  logic [ETHCOUNT-1:0]   rx_valid,
  input  logic [ETHCOUNT-1:0]   rx_sof,
  input  logic [ETHCOUNT-1:0]   rx_eof,
  input  logic [ETHCOUNT-1:0]   rx_err,
  output logic [ETHCOUNT*8-1:0] tx_data,
  output logic [ETHCOUNT-1:0]   tx_valid,
  output logic [ETHCOUNT-1:0]   tx_sof,
  output logic [ETHCOUNT-1:0]   tx_eof,
  output logic [ETHCOUNT-1:0]   drop_pulse
`ifdef ETH_FWD_STATS_EN
  ,
  output logic [ETHCOUNT*32-1:0] stat_rx_frames,
  output logic [ETHCOUNT*32-1:0] stat_drop_frames,
  output logic [ETHCOUNT*32-1:0] stat_tx_frames
`endif
);
  logic [WORD_W-1:0] rd_word [ETHCOUNT];
  logic [ETHCOUNT-1:0] has_frame, rd_go, rd_last, buf_rd, buf_done, idle;
  logic swap_q, swap_d;
  // The route only changes while every output is idle, so decisions this cycle already use it.
  always_comb swap_d = ETHCOUNT % 2 == 0 && (&idle ? cfg_swap : swap_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) swap_q <= 1'b0;
    else swap_q <= swap_d;
  for (genvar g = 0; g < ETHCOUNT; g++) begin : g_ch
    localparam int ALT = route_src(g, 1'b1) < ETHCOUNT ? route_src(g, 1'b1) : g;
    fsm_e state_q, state_d;
    logic [7:0] gap_q, gap_d, data_q, data_d;
    logic valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
    logic [WORD_W-1:0] word;
    logic avail;
    eth_fwd_chan_buf #(.DEPTH(DEPTH)) u_buf (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data[g*8 +: 8]),
      .rx_valid(rx_valid[g]),
      .rx_sof(rx_sof[g]),
      .rx_eof(rx_eof[g]),
      .rx_err(rx_err[g]),
      .rd_en(buf_rd[g]),
      .rd_done(buf_done[g]),
      .rd_word(rd_word[g]),
      .has_frame(has_frame[g]),
      .drop_pulse(drop_pulse[g])
`ifdef ETH_FWD_STATS_EN
      ,
      .stat_rx(stat_rx_frames[g*32 +: 32]),
      .stat_drop(stat_drop_frames[g*32 +: 32])
`endif
    );
    assign word = swap_d ? rd_word[ALT] : rd_word[g];
    assign avail = swap_d ? has_frame[ALT] : has_frame[g];
    assign rd_go[g] = state_q == SEND;
    assign rd_last[g] = rd_go[g] & word[LAST_BIT];
    assign buf_rd[g] = swap_d ? rd_go[ALT] : rd_go[g];
    assign buf_done[g] = swap_d ? rd_last[ALT] : rd_last[g];
    assign idle[g] = state_q == IDLE;
    // GAP lasts IFG_CYCLES-1 cycles; the IDLE decision cycle supplies the final idle tx cycle.
    always_comb begin
      state_d = state_q;
      gap_d = gap_q - 8'd1;
      data_d = '0;
      valid_d = 1'b0;
      sof_d = 1'b0;
      eof_d = 1'b0;
      case (state_q)
        IDLE: state_d = avail ? SEND : IDLE;
        SEND: begin
          valid_d = 1'b1;
          sof_d = ~valid_q;
          eof_d = word[LAST_BIT];
          data_d = word[7:0];
          state_d = word[LAST_BIT] ? GAP : SEND;
          gap_d = 8'(IFG_CYCLES - 2);
        end
        default: state_d = gap_q == '0 ? IDLE : GAP;
      endcase
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state_q <= IDLE;
        gap_q <= '0;
        data_q <= '0;
        valid_q <= 1'b0;
        sof_q <= 1'b0;
        eof_q <= 1'b0;
      end else begin
        state_q <= state_d;
        gap_q <= gap_d;
        data_q <= data_d;
        valid_q <= valid_d;
        sof_q <= sof_d;
        eof_q <= eof_d;
      end
    assign tx_data[g*8 +: 8] = data_q;
    assign tx_valid[g] = valid_q;
    assign tx_sof[g] = sof_q;
    assign tx_eof[g] = eof_q;
`ifdef ETH_FWD_STATS_EN
    logic [31:0] stat_tx_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) stat_tx_q <= '0;
      else stat_tx_q <= stat_tx_q + 32'(eof_d);
    assign stat_tx_frames[g*32 +: 32] = stat_tx_q;
`endif
  end
endmodule

// File: doc/eth_frame_fwd.md
Name: eth_frame_fwd

Overview:
- Multi-channel store-and-forward frame forwarder between the RGMII MAC receive and transmit byte streams, one clock domain (gtx clock).
- Replaces the plain one-cycle registered rx-to-tx loopback.
- Buffers whole frames per channel, drops errored or oversize frames, and emits gapless tx frames with an enforced inter-frame gap.
- Supports runtime straight (ch i -> ch i) or pair-swap (ch i -> ch i^1) routing.

Parameters:
- ETHCOUNT, 4, number of channels (1..8; must be even for swap mode).
- DEPTH, 2048, per-channel buffer depth in bytes (power of 2); maximum accepted frame is DEPTH-1 bytes.
- IFG_CYCLES, 12, idle cycles forced on tx after each eof.

Ports:
- clk  in  1  gtx clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_swap  in  1  routing mode: 0 straight, 1 pair-swap.
- rx_data  in  ETHCOUNT*8  rx byte per channel; channel x uses [x*8 +: 8].
- rx_valid  in  ETHCOUNT  byte valid.
- rx_sof  in  ETHCOUNT  first byte of frame.
- rx_eof  in  ETHCOUNT  last byte of frame.
- rx_err  in  ETHCOUNT  frame bad; sampled only together with rx_eof.
- tx_data  out  ETHCOUNT*8  tx byte.
- tx_valid  out  ETHCOUNT  byte valid; contiguous for the whole frame.
- tx_sof  out  ETHCOUNT  first byte.
- tx_eof  out  ETHCOUNT  last byte.
- drop_pulse  out  ETHCOUNT  one-cycle pulse per dropped frame.

Behaviour:
- Reset: all tx_*, drop_pulse = 0; FSMs in IDLE; pointers = 0; frame counts = 0; active route = straight.
- Buffer storage: each channel has a DEPTH x 9 RAM holding {last, data}.
- Pointers: wr_ptr, wr_commit and rd_ptr, each $clog2(DEPTH) bits wide, with wrap-around.
- Write side, per channel:
  - rx_valid & rx_sof: wr_ptr reloads to wr_commit. Any uncommitted partial frame is discarded silently, with no drop_pulse. The byte is then written as the first byte.
  - Bytes are written only when rx_valid=1; rx gaps mid-frame are allowed.
  - Full condition: wr_ptr+1 == rd_ptr. A valid byte while full sets the ovf flag and is not written.
  - eof, good case (rx_err=0 and ovf=0): byte stored with last=1, wr_commit <= wr_ptr+1, frame count +1.
  - eof, bad case (rx_err=1 or ovf=1): wr_ptr <= wr_commit, drop_pulse=1 for one cycle, ovf cleared.
  - sof and eof in the same cycle is a valid 1-byte frame.
  - Bytes without a preceding sof are ignored.
- Read side, per output channel, FSM IDLE -> SEND -> GAP -> IDLE:
  - IDLE: if the routed source's frame count > 0, go to SEND and issue the first RAM read.
  - SEND: one read per cycle. tx_valid=1 every cycle. tx_sof on the first byte. tx_eof when last=1, then go to GAP and decrement the source frame count.
  - GAP: IFG_CYCLES cycles with tx_valid=0, then IDLE.
- Latency: eof of a good frame sampled at edge N with the output in IDLE gives tx_valid/tx_sof high after edge N+2.
- Commit and send-complete in the same cycle on one source: frame count is unchanged.
- cfg_swap change is applied only in a cycle where every output FSM is in IDLE. It is never applied mid-frame or mid-gap.
- With ETHCOUNT odd, cfg_swap is ignored.
- Reset asserted mid-frame: everything aborts immediately and all buffered frames are lost.

Optional Feature:
- Macro ETH_FWD_STATS_EN.
- When defined, adds these outputs:
  - stat_rx_frames, ETHCOUNT*32: good frames committed.
  - stat_drop_frames, ETHCOUNT*32: drops.
  - stat_tx_frames, ETHCOUNT*32: tx eofs.
- Counters wrap at 2^32 and reset to 0 with rst.
- When undefined, these ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Package eth_fwd_pkg holds:
  - FSM state enum (IDLE, SEND, GAP).
  - 9-bit buffer word layout constants (LAST_BIT=8).
  - Route-select function: src = swap ? ch^1 : ch.
- One sub-module, eth_fwd_chan_buf: per-channel RAM, write/commit logic and frame count; read port driven by the top.
- The top instantiates ETHCOUNT buffers via generate, plus the routing and output FSMs.

Test Plan:
- Straight loopback: ch0 receives a 64-byte frame (0x00..0x3F) with rx_err=0. Required: tx ch0 emits identical 64 bytes starting 2 cycles after eof, with sof on 0x00, eof on 0x3F, no valid gaps.
- Errored frame: ch1 60-byte frame with rx_err=1 at eof. Required: drop_pulse[1] for 1 cycle and no tx on ch1. A following good frame is forwarded intact.
- Overflow: DEPTH=64, send a 70-byte frame. Required: it is dropped with drop_pulse. A following 63-byte frame is forwarded (fills to exactly full-1).
- IFG and back-to-back: two 10-byte frames buffered on ch2. Required: exactly 12 idle cycles between the first tx_eof and the second tx_sof.
- Swap: cfg_swap=1 while idle; frames on ch0 and ch1. Required: ch0 data appears on tx ch1 and vice versa. Toggling cfg_swap mid-frame does not alter the in-flight frame.
- Abort: sof, 20 bytes, then a new sof on ch3 without eof. Required: the first partial is discarded with no drop_pulse and only the second frame is transmitted.
